// File: rtl/cpmg_pulse_sequencer.sv
// Multi-channel CPMG pulse/echo timing generator driven by one free-running period counter.
// Config is shadowed at the period boundary so a host update never tears a running sequence.
module cpmg_pulse_sequencer #(
  parameter int NCH      = 2,
  parameter int CW       = 32,
  parameter int TW       = 16,
  parameter int AW       = 7,
  parameter int ATT_STEP = 6,
  parameter int GUARD    = 20
) (
  input  logic              clk_pll,
  input  logic              reset,
  input  logic [CW-1:0]     per,
  input  logic              cw_mode,
  input  logic [NCH-1:0]    cw_mask,
  input  logic [NCH*TW-1:0] p1st,
  input  logic [NCH*TW-1:0] p1wid,
  input  logic [NCH*TW-1:0] del,
  input  logic [NCH*TW-1:0] p2wid,
  input  logic [NCH*8-1:0]  npi,
  input  logic [AW-1:0]     pr_att,
  output logic              sync_on,
  output logic [NCH-1:0]    pulse_on,
  output logic [AW-1:0]     pre_att,
  output logic              pre_block,
  output logic              period_start
);

  typedef enum logic [2:0] {WAIT_P1, P1, WAIT_PI, PI, DONE} ch_state_t;

  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a);
    logic [AW:0] sum;
    sum = {1'b0, a} + (AW+1)'(ATT_STEP);
    return sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
  endfunction

  logic [CW-1:0]     per_sh;
  logic              cw_sh;
  logic [NCH-1:0]    mask_sh;
  logic [NCH*TW-1:0] p1st_sh, p1wid_sh, del_sh, p2wid_sh;
  logic [NCH*8-1:0]  npi_sh;
  logic [AW-1:0]     pr_att_sh;

  logic [CW-1:0] cnt;
  logic [CW-1:0] period;
  logic          last;

  assign period = (per_sh < CW'(2)) ? CW'(2) : per_sh;
  assign last   = (cnt == period - CW'(1));

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk_pll) begin
    if (reset || last) begin
      per_sh    <= per;
      cw_sh     <= cw_mode;
      mask_sh   <= cw_mask;
      p1st_sh   <= p1st;
      p1wid_sh  <= p1wid;
      del_sh    <= del;
      p2wid_sh  <= p2wid;
      npi_sh    <= npi;
      pr_att_sh <= pr_att;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (reset || last) cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

  logic [NCH-1:0] pulse_act;
  logic [NCH-1:0] p1_act;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CW-1:0] s, w1, d, w2;
    logic [7:0]    n;
    ch_state_t     st_q, st_d;
    logic [CW-1:0] edge_q, edge_d;
    logic [7:0]    pc_q, pc_d;

    assign s  = CW'(p1st_sh[k*TW +: TW]);
    assign w1 = CW'(p1wid_sh[k*TW +: TW]);
    assign d  = CW'(del_sh[k*TW +: TW]);
    assign w2 = CW'(p2wid_sh[k*TW +: TW]);
    assign n  = npi_sh[k*8 +: 8];

    // Resolve the state that applies at the current count; the chained ifs let
    // zero-length phases fall through in the same cycle.
    // NOTE: every variable gets a default at the top so no path leaves it unassigned,
    // which keeps this block free of inferred latches.
    always_comb begin
      st_d   = st_q;
      edge_d = edge_q;
      pc_d   = pc_q;
      if (st_d == WAIT_P1 && cnt == s) begin
        st_d   = P1;
        edge_d = s + w1;
      end
      if (st_d == P1 && cnt == edge_d) begin
        st_d   = WAIT_PI;
        edge_d = edge_d + d;
      end
      if (st_d == WAIT_PI && cnt == edge_d) begin
        if (w2 == '0 || pc_d == n) begin
          st_d = DONE;
        end else begin
          st_d   = PI;
          edge_d = edge_d + w2;
        end
      end
      if (st_d == PI && cnt == edge_d) begin
        pc_d = pc_d + 8'd1;
        if (pc_d == n) begin
          st_d = DONE;
        end else begin
          st_d   = WAIT_PI;
          edge_d = edge_d + d + d;
        end
      end
      // A zero tau re-enters the next pi pulse immediately.
      if (st_d == WAIT_PI && cnt == edge_d) begin
        st_d   = PI;
        edge_d = edge_d + w2;
      end
    end

    always_ff @(posedge clk_pll) begin
      if (reset || last || cw_sh) begin
        st_q   <= WAIT_P1;
        edge_q <= '0;
        pc_q   <= '0;
      end else begin
        st_q   <= st_d;
        edge_q <= edge_d;
        pc_q   <= pc_d;
      end
    end

    assign pulse_act[k] = (st_d == P1) || (st_d == PI);
    assign p1_act[k]    = (st_d == P1);
  end

  logic [CW-1:0] sync_end;
  logic          in_guard;
  logic          mode_q;

  assign sync_end = CW'(p1st_sh[0 +: TW]) + CW'(p1wid_sh[0 +: TW])
                  + CW'(del_sh[0 +: TW])  + CW'(p2wid_sh[0 +: TW]);
  assign in_guard = (period > CW'(GUARD)) && (cnt >= period - CW'(GUARD));

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      sync_on      <= 1'b0;
      pulse_on     <= '0;
      pre_att      <= sat_add(pr_att);
      pre_block    <= 1'b0;
      period_start <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      period_start <= (cnt == '0);
      sync_on      <= (cnt < sync_end);
      pulse_on     <= cw_sh ? mask_sh : pulse_act;
      mode_q       <= cw_sh;
      // Second stage: follows pulse_on by one cycle, forced high in CW mode.
      pre_block    <= mode_q | (|pulse_on);
      if (!cw_sh && ((|p1_act) || in_guard)) pre_att <= sat_add(pr_att_sh);
      else                                   pre_att <= pr_att_sh;
    end
  end

endmodule

// File: tb/tb_cpmg_pulse_sequencer.sv
// Scoreboard bench: a formula-level model predicts every output per cycle and the
// prediction is compared against the DUT one clock later.
`timescale 1ns/1ps
module tb_cpmg_pulse_sequencer;
  localparam int NCH = 2, CW = 32, TW = 16, AW = 7, ATT_STEP = 6, GUARD = 20;
  localparam logic [AW-1:0] ATT_MAX = {AW{1'b1}};

  logic              clk_pll = 1'b0;
  logic              reset   = 1'b1;
  logic [CW-1:0]     per     = '0;
  logic              cw_mode = 1'b0;
  logic [NCH-1:0]    cw_mask = '0;
  logic [NCH*TW-1:0] p1st = '0, p1wid = '0, del = '0, p2wid = '0;
  logic [NCH*8-1:0]  npi  = '0;
  logic [AW-1:0]     pr_att = '0;
  logic              sync_on, pre_block, period_start;
  logic [NCH-1:0]    pulse_on;
  logic [AW-1:0]     pre_att;

  cpmg_pulse_sequencer #(
    .NCH(NCH), .CW(CW), .TW(TW), .AW(AW), .ATT_STEP(ATT_STEP), .GUARD(GUARD)
  ) dut (
    .clk_pll(clk_pll), .reset(reset), .per(per), .cw_mode(cw_mode), .cw_mask(cw_mask),
    .p1st(p1st), .p1wid(p1wid), .del(del), .p2wid(p2wid), .npi(npi), .pr_att(pr_att),
    .sync_on(sync_on), .pulse_on(pulse_on), .pre_att(pre_att), .pre_block(pre_block),
    .period_start(period_start)
  );

  always #2.5 clk_pll = ~clk_pll;

  typedef struct {
    logic           sync;
    logic [NCH-1:0] pulse;
    logic [AW-1:0]  att;
    logic           blk;
    logic           ps;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "reset";

  // Model state: counter and shadow copies of the configuration.
  longint            m_t = 0;
  logic [CW-1:0]     m_per;
  logic              m_cw;
  logic [NCH-1:0]    m_mask;
  logic [NCH*TW-1:0] m_p1st, m_p1wid, m_del, m_p2wid;
  logic [NCH*8-1:0]  m_npi;
  logic [AW-1:0]     m_att;
  logic [NCH-1:0]    prev_pulse = '0;
  logic              prev_mode  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d expected %0d (t=%0d)", phase, tag, got, exp, m_t);
    end
  endtask

  function automatic logic [AW-1:0] sat(input logic [AW-1:0] a);
    int v;
    v = int'(a) + ATT_STEP;
    return (v > int'(ATT_MAX)) ? ATT_MAX : AW'(v);
  endfunction

  function automatic longint model_p();
    return (m_per < 2) ? 2 : longint'(m_per);
  endfunction

  function automatic logic in_first(input int k, input longint t);
    longint s, w1;
    s  = longint'(m_p1st[k*TW +: TW]);
    w1 = longint'(m_p1wid[k*TW +: TW]);
    return (t >= s) && (t < s + w1);
  endfunction

  function automatic logic in_pi(input int k, input longint t);
    longint s, w1, d, w2, a;
    int n;
    s  = longint'(m_p1st[k*TW +: TW]);
    w1 = longint'(m_p1wid[k*TW +: TW]);
    d  = longint'(m_del[k*TW +: TW]);
    w2 = longint'(m_p2wid[k*TW +: TW]);
    n  = int'(m_npi[k*8 +: 8]);
    for (int j = 0; j < n; j++) begin
      a = s + w1 + d + longint'(j) * (w2 + 2 * d);
      if (t >= a && t < a + w2) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic load_shadows();
    m_per = per; m_cw = cw_mode; m_mask = cw_mask; m_p1st = p1st; m_p1wid = p1wid;
    m_del = del; m_p2wid = p2wid; m_npi = npi; m_att = pr_att;
  endtask

  task automatic step();
    exp_t   e, g;
    longint p, sync_end;
    logic   any_first;
    e.sync = 1'b0; e.pulse = '0; e.att = '0; e.blk = 1'b0; e.ps = 1'b0;
    p = model_p();
    if (reset) begin
      e.att = sat(pr_att);
    end else begin
      any_first = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        if (m_cw) e.pulse[k] = m_mask[k];
        else      e.pulse[k] = in_first(k, m_t) || in_pi(k, m_t);
        if (!m_cw && in_first(k, m_t)) any_first = 1'b1;
      end
      sync_end = longint'(m_p1st[0 +: TW]) + longint'(m_p1wid[0 +: TW])
               + longint'(m_del[0 +: TW]) + longint'(m_p2wid[0 +: TW]);
      e.sync = (m_t < sync_end);
      e.ps   = (m_t == 0);
      e.blk  = prev_mode | (|prev_pulse);
      if (!m_cw && (any_first || (p > GUARD && m_t >= p - GUARD))) e.att = sat(m_att);
      else                                                          e.att = m_att;
    end
    sb.push_back(e);
    @(posedge clk_pll);
    #1;
    if (reset) begin
      m_t = 0; load_shadows(); prev_pulse = '0; prev_mode = 1'b0;
    end else begin
      prev_pulse = e.pulse; prev_mode = m_cw;
      if (m_t == p - 1) begin m_t = 0; load_shadows(); end
      else m_t++;
    end
    g = sb.pop_front();
    check("sync_on",      32'(sync_on),      32'(g.sync));
    check("pulse_on",     32'(pulse_on),     32'(g.pulse));
    check("pre_att",      32'(pre_att),      32'(g.att));
    check("pre_block",    32'(pre_block),    32'(g.blk));
    check("period_start", 32'(period_start), 32'(g.ps));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance to a given model count, bounded so a stuck counter cannot hang the bench.
  task automatic run_to(input longint t);
    int guard_cnt;
    guard_cnt = 0;
    while (m_t != t && guard_cnt < 300) begin
      step();
      guard_cnt++;
    end
    check("run_to_reached", 32'(m_t == t), 32'd1);
  endtask

  task automatic set_ch(input int k, input int s, input int w1, input int d,
                        input int w2, input int n);
    p1st[k*TW +: TW]  = TW'(s);
    p1wid[k*TW +: TW] = TW'(w1);
    del[k*TW +: TW]   = TW'(d);
    p2wid[k*TW +: TW] = TW'(w2);
    npi[k*8 +: 8]     = 8'(n);
  endtask

  initial begin
    // Reset with all widths zero, short period.
    per = 10; pr_att = 10; reset = 1'b1;
    run(3);
    reset = 1'b0; phase = "period";
    run(25);

    // Hahn echo on ch0, longer period so the guard interval is exercised.
    phase = "hahn";
    per = 40; set_ch(0, 5, 4, 10, 8, 1); set_ch(1, 2, 3, 1, 2, 2);
    run_to(0);
    run(40);

    // CPMG train with three pi pulses.
    phase = "cpmg";
    set_ch(0, 0, 2, 3, 4, 3); set_ch(1, 3, 1, 2, 1, 4);
    run_to(0);
    run(40);

    // Mid-period config change must wait for the boundary.
    phase = "shadow";
    run_to(15);
    p1wid[0 +: TW] = 16'd6;
    run_to(0);
    run(40);
    run_to(12);
    reset = 1'b1; run(1); reset = 1'b0;
    run(10);

    // Pi train running past the period end gets truncated.
    phase = "trunc";
    per = 20; set_ch(0, 2, 2, 3, 4, 5);
    run_to(0);
    run(40);

    // Zero tau merges windows; high base attenuation saturates.
    phase = "abut_sat";
    set_ch(0, 1, 3, 0, 2, 3); pr_att = 125;
    run_to(0);
    run(40);

    // Period below two.
    phase = "per1";
    per = 1; pr_att = 20;
    run_to(0);
    run(8);

    // CW mode and return to pulsed mode.
    phase = "cw";
    per = 10; cw_mode = 1'b1; cw_mask = 2'b10; set_ch(0, 1, 2, 1, 2, 1);
    run_to(0);
    run(20);
    cw_mode = 1'b0;
    run_to(0);
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
